// File: rtl/dual_prio_encoder_pipe.sv
// Two-stage pipelined dual priority encoder: captures a request vector, then encodes the
// highest and second-highest set bits into codes for the downstream one-hot decoders.
module dual_prio_encoder_pipe #(
  parameter int REQ_W  = 12,
  parameter int CODE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REQ_W-1:0]  req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] first_code,
  output logic              first_found,
  output logic [CODE_W-1:0] second_code,
  output logic              second_found,
  output logic              busy
);

  logic              s1_valid;
  logic [REQ_W-1:0]  s1_req;
  logic              s2_ready;
  logic              accept;
  logic              s2_load;
  logic [CODE_W-1:0] enc_first;
  logic [CODE_W-1:0] enc_second;
  logic              enc_first_found;
  logic              enc_second_found;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid && s2_ready;
  assign busy     = s1_valid || out_valid;

  // Ascending scan: each newly found bit demotes the previous leader to second place,
  // so codes stay 0 whenever their found flag is 0.
  always_comb begin
    enc_first        = '0;
    enc_first_found  = 1'b0;
    enc_second       = '0;
    enc_second_found = 1'b0;
    for (int i = 0; i < REQ_W; i++) begin
      if (s1_req[i]) begin
        enc_second       = enc_first;
        enc_second_found = enc_first_found;
        enc_first        = CODE_W'(i);
        enc_first_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else begin
      if (accept) begin
        s1_req   <= req;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      first_code   <= '0;
      first_found  <= 1'b0;
      second_code  <= '0;
      second_found <= 1'b0;
    end else if (s2_load) begin
      out_valid    <= 1'b1;
      first_code   <= enc_first;
      first_found  <= enc_first_found;
      second_code  <= enc_second;
      second_found <= enc_second_found;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_prio_encoder_pipe.sv
// Scoreboard bench for dual_prio_encoder_pipe: accepted vectors push a reference result,
// a monitor pops and compares on every output transfer.
module tb_dual_prio_encoder_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  first_code;
  logic        first_found;
  logic [3:0]  second_code;
  logic        second_found;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int run_len  = 0;
  int max_run  = 0;
  logic rand_bp = 1'b0;

  logic [9:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out   = '0;

  dual_prio_encoder_pipe #(.REQ_W(12), .CODE_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .first_code(first_code),
    .first_found(first_found), .second_code(second_code), .second_found(second_found),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: list set bit indices from the top; first and second entries are the answers.
  function automatic logic [9:0] model(input logic [11:0] v);
    int idx[$];
    logic [4:0] f, s;
    f = '0;
    s = '0;
    for (int i = 11; i >= 0; i--) if (v[i]) idx.push_back(i);
    if (idx.size() > 0) f = {1'b1, idx[0][3:0]};
    if (idx.size() > 1) s = {1'b1, idx[1][3:0]};
    return {f, s};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] out_word();
    return {first_found, first_code, second_found, second_code};
  endfunction

  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) exp_q.push_back(model(req));
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      if (prev_stall) check("stall_hold", {22'd0, out_valid, out_word()}, {22'd0, 1'b1, prev_out});
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {22'd0, out_word()}, 32'hFFFF_FFFF);
        end else begin
          check("result", {22'd0, out_word()}, {22'd0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = out_word();
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called and returns at posedge+1; holds req until the vector is accepted.
  task automatic send(input logic [11:0] v);
    int t = 0;
    in_valid = 1'b1;
    req      = v;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    reset     = 1'b1;
    in_valid  = 1'b0;
    req       = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_codes", {22'd0, out_word()}, 32'd0);

    // Single vector, latency and drop
    @(posedge clk); #1;
    in_valid = 1'b1;
    req      = 12'b0010_0100_0000;
    @(negedge clk);
    check("single_accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_c1_out_valid", {31'd0, out_valid}, 32'd0);
    check("latency_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("latency_c2_out_valid", {31'd0, out_valid}, 32'd1);
    check("single_first_code", {28'd0, first_code}, 32'd9);
    check("single_second_code", {28'd0, second_code}, 32'd6);
    check("single_flags", {30'd0, first_found, second_found}, 32'd3);
    @(negedge clk);
    check("single_drop", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Edge cases
    send(12'h800);
    send(12'h000);
    send(12'hFFF);
    send(12'h003);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(12'h001);
    send(12'h002);
    in_valid = 1'b1;
    req      = 12'h004;
    @(negedge clk);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_first_code", {28'd0, first_code}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(12'h008);
    drain();

    // Full-rate random stream
    max_run     = 0;
    pops_before = n_pops;
    for (int i = 0; i < 20; i++) send(12'($urandom()));
    drain();
    check("stream_count", n_pops - pops_before, 32'd20);
    check("stream_no_bubbles", max_run, 32'd20);

    // Random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++) send(12'($urandom()));
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Reset mid-operation with both stages full
    out_ready = 1'b0;
    send(12'h0F0);
    send(12'h00F);
    @(negedge clk);
    check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset       = 1'b0;
    out_ready   = 1'b1;
    pops_before = n_pops;
    send(12'h400);
    drain();
    check("post_reset_count", n_pops - pops_before, 32'd1);
    repeat (5) @(negedge clk);
    check("no_stale_results", n_pops - pops_before, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_prio_encoder_pipe.md
Name: dual_prio_encoder_pipe

Overview:
- Pipelined dual priority encoder. The inverse of the existing 4-to-12 one-hot decoder.
- Accepts a 12-bit request vector through a valid/ready handshake.
- Returns two 4-bit codes: the highest-priority set bit (`first`) and the second-highest set bit (`second`), each with its own found flag.
- Sits between request-collection logic and the downstream 4-to-12 decoders. The decoders regenerate the one-hot grant lines from the codes.

Parameters:
- REQ_W, 12, width of the request vector. Legal range 2..16.
- CODE_W, 4, code width. Must satisfy 2^CODE_W >= REQ_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  req holds a valid vector this cycle
- in_ready  output  1  block accepts req this cycle
- req  input  REQ_W  request vector; bit REQ_W-1 has the highest priority
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  downstream accepts the result this cycle
- first_code  output  CODE_W  index of the highest set bit
- first_found  output  1  at least one bit was set
- second_code  output  CODE_W  index of the next-highest set bit below first_code
- second_found  output  1  at least two bits were set
- busy  output  1  any pipeline stage holds data

Behaviour:
- **Reset.** Synchronous, active-high; reset wins over every other event in the same cycle. After reset:
  - s1_valid = 0 and out_valid = 0.
  - first_code, second_code, first_found, second_found = 0.
  - busy = 0; in_ready = 1 in the first cycle after reset.
  - Asserting reset mid-operation discards all in-flight vectors; nothing is emitted for them.
- **Stage 1 (capture).**
  - On in_valid && in_ready, req is registered into s1_req and s1_valid is set.
  - If s1_valid is held and stage 2 does not advance, s1_req is held unchanged.
- **Stage 2 (encode).** Combinational from s1_req, registered into the output registers when s1_valid && s2_ready.
  - first_code = index of the highest set bit; first_found = |s1_req.
  - second_code = highest set bit of s1_req with the first bit cleared; second_found = popcount >= 2.
  - A code is forced to 0 when its found flag is 0.
- **Handshake.**
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready. This is combinational; in_ready must not depend on in_valid.
  - out_valid is set when stage 2 loads. It clears on out_ready when no new load occurs that cycle.
  - Output registers are stable while out_valid && !out_ready.
- **Latency and throughput.**
  - Latency is 2 cycles from the accept edge to out_valid, with no stalls.
  - Throughput is 1 vector per cycle while out_ready = 1.
  - Full back-to-back streaming requires no bubbles.
- **Zero vector.** req = 0 is a legal transaction. It produces out_valid with both found flags 0 and both codes 0.
- **Simultaneous events.** Accept into stage 1, advance to stage 2, and drain of the output may all occur in the same cycle; no data may be lost or duplicated.
- **Full condition.** With both stages full and out_ready = 0, in_ready = 0. The first cycle out_ready = 1, both stages shift and in_ready = 1 in that same cycle.
- **Ordering.** Results are emitted strictly in acceptance order.
- **busy.** busy = s1_valid || out_valid.

Test Plan:
- Reset then idle: reset held for 3 cycles -> out_valid = 0, in_ready = 1, busy = 0, all codes 0.
- Single vector: req = 12'b0010_0100_0000 with out_ready = 1 -> 2 cycles later out_valid = 1, first_code = 9, second_code = 6, both found flags = 1. out_valid drops the next cycle.
- Edge cases:
  - req = 12'h800 -> first_code = 11, first_found = 1, second_found = 0, second_code = 0.
  - req = 0 -> both found flags 0.
  - req = 12'hFFF -> first_code = 11, second_code = 10.
  - req = 12'h003 -> first_code = 1, second_code = 0, second_found = 1.
- Backpressure: stream 12'h001, 12'h002, 12'h004, 12'h008 with out_ready = 0 ->
  - in_ready drops after 2 accepts.
  - Outputs are held stable at first_code = 0.
  - On releasing out_ready, results 0, 1, 2, 3 arrive in order with no loss or duplication.
- Full-rate stream: 20 random vectors with in_valid = 1 and out_ready = 1 -> 20 consecutive results, each matching the reference model, with no bubbles after the initial 2-cycle latency.
- Reset mid-operation: reset asserted with both stages full -> the next cycle out_valid = 0 and busy = 0. A new vector 12'h400 then yields first_code = 10 only, and no stale results appear.
